// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters that gate instruction issue on RAW hazards
// and on WAW depth, with optional same-cycle writeback bypass.
module regfile_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int NUM_SRC     = 2,
    parameter int NUM_WB      = 2,
    parameter int MAX_PENDING = 3,
    parameter bit WB_BYPASS   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 issue_valid_i,
    input  logic                 issue_we_i,
    input  logic [4:0]           issue_rd_i,
    input  logic [NUM_SRC-1:0]   src_check_i,
    input  logic [5*NUM_SRC-1:0] src_addr_i,
    output logic                 issue_ready_o,
    output logic                 hazard_o,
    input  logic [NUM_WB-1:0]    wb_valid_i,
    input  logic [5*NUM_WB-1:0]  wb_rd_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 error_o
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int RW = $clog2(NUM_WB + 1);
    // One spare bit so count arithmetic never wraps before the saturation compare.
    localparam int KW = ((CW > RW) ? CW : RW) + 1;

    // Handshake: an instruction is accepted in the cycle where issue_valid_i && issue_ready_o;
    // issue_ready_o is combinational and never depends on issue_valid_i.
    logic [CW-1:0] cnt [NUM_REGS];
    logic [KW-1:0] ret [NUM_REGS];
    logic [KW-1:0] dec [NUM_REGS];
    logic [KW-1:0] nxt [NUM_REGS];
    logic [CW-1:0] eff [NUM_REGS];
    logic          under;
    logic          waw_full;
    logic          fire;

    always_comb begin
        under = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ret[r] = '0;
            for (int j = 0; j < NUM_WB; j++) begin
                if (r != 0 && wb_valid_i[j] && wb_rd_i[5*j +: 5] == 5'(r))
                    ret[r] = ret[r] + KW'(1);
            end
            dec[r] = (ret[r] > KW'(cnt[r])) ? KW'(cnt[r]) : ret[r];
            if (ret[r] > KW'(cnt[r]))
                under = 1'b1;
            eff[r] = WB_BYPASS ? CW'(KW'(cnt[r]) - dec[r]) : cnt[r];
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_check_i[i] && src_addr_i[5*i +: 5] != 5'd0 &&
                eff[src_addr_i[5*i +: 5]] != '0)
                hazard_o = 1'b1;
        end
    end

    assign waw_full      = issue_we_i && issue_rd_i != 5'd0 &&
                           eff[issue_rd_i] == CW'(MAX_PENDING);
    assign issue_ready_o = !hazard_o && !waw_full && !flush_i;
    assign fire          = issue_valid_i && issue_ready_o && issue_we_i && issue_rd_i != 5'd0;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            nxt[r] = KW'(cnt[r]) - dec[r] + KW'(fire && issue_rd_i == 5'(r));
    end

    always_comb begin
        busy_o = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            if (cnt[r] != '0)
                busy_o = 1'b1;
    end

    // Flush discards same-cycle issue and retire; error_o survives everything but reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            error_o <= 1'b0;
        end else if (flush_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= (r == 0) ? '0 : CW'(nxt[r]);
            if (under)
                error_o <= 1'b1;
        end
    end

    no_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(fire && !flush_i && nxt[issue_rd_i] > KW'(MAX_PENDING)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a count-per-register model.
module tb_regfile_scoreboard;
    localparam int WB_BYPASS = 1;
    localparam int MAXP      = 3;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       issue_valid_i;
    logic       issue_we_i;
    logic [4:0] issue_rd_i;
    logic [1:0] src_check_i;
    logic [9:0] src_addr_i;
    logic       issue_ready_o;
    logic       hazard_o;
    logic [1:0] wb_valid_i;
    logic [9:0] wb_rd_i;
    logic       flush_i;
    logic       busy_o;
    logic       error_o;

    int vectors     = 0;
    int miscompares = 0;
    int mcnt [32];
    bit merr;

    regfile_scoreboard #(
        .NUM_REGS(32), .NUM_SRC(2), .NUM_WB(2), .MAX_PENDING(MAXP), .WB_BYPASS(1'b1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_rd_i(issue_rd_i),
        .src_check_i(src_check_i), .src_addr_i(src_addr_i),
        .issue_ready_o(issue_ready_o), .hazard_o(hazard_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .flush_i(flush_i), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] chk, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] wv, input logic [4:0] w0, input logic [4:0] w1,
                         input logic fl);
        issue_valid_i = v;
        issue_we_i    = we;
        issue_rd_i    = rd;
        src_check_i   = chk;
        src_addr_i    = {s1, s0};
        wb_valid_i    = wv;
        wb_rd_i       = {w1, w0};
        flush_i       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
    endtask

    // Compare combinational and registered outputs against the model, then advance one edge.
    task automatic step(input string tag);
        int ret [32];
        int eff [32];
        int nxt [32];
        int d;
        int a;
        bit hz, full, rdy, fire, busy, nerr;
        #1;
        for (int r = 0; r < 32; r++) ret[r] = 0;
        for (int j = 0; j < 2; j++)
            if (wb_valid_i[j] && wb_rd_i[5*j +: 5] != 5'd0)
                ret[wb_rd_i[5*j +: 5]]++;
        for (int r = 0; r < 32; r++) begin
            d = (ret[r] < mcnt[r]) ? ret[r] : mcnt[r];
            eff[r] = (WB_BYPASS != 0) ? mcnt[r] - d : mcnt[r];
        end
        hz = 0;
        for (int i = 0; i < 2; i++) begin
            a = int'(src_addr_i[5*i +: 5]);
            if (src_check_i[i] && a != 0 && eff[a] != 0) hz = 1;
        end
        full = issue_we_i && issue_rd_i != 0 && eff[issue_rd_i] == MAXP;
        rdy  = !hz && !full && !flush_i;
        fire = issue_valid_i && rdy && issue_we_i && issue_rd_i != 0;
        busy = 0;
        for (int r = 0; r < 32; r++) if (mcnt[r] != 0) busy = 1;
        check({tag, "_hazard"}, 32'(hazard_o), 32'(hz));
        check({tag, "_ready"}, 32'(issue_ready_o), 32'(rdy));
        check({tag, "_busy"}, 32'(busy_o), 32'(busy));
        check({tag, "_error"}, 32'(error_o), 32'(merr));
        nerr = merr;
        for (int r = 0; r < 32; r++) begin
            if (flush_i) nxt[r] = 0;
            else begin
                d = (ret[r] < mcnt[r]) ? ret[r] : mcnt[r];
                if (ret[r] > mcnt[r]) nerr = 1;
                nxt[r] = mcnt[r] - d + ((fire && issue_rd_i == 5'(r)) ? 1 : 0);
            end
        end
        @(posedge clk_i);
        for (int r = 0; r < 32; r++) mcnt[r] = nxt[r];
        merr = nerr;
        #1;
    endtask

    task automatic rand_cycle(input bit wild);
        logic [1:0] wv;
        logic [4:0] w [2];
        int avail [8];
        for (int k = 0; k < 8; k++) avail[k] = mcnt[k];
        for (int j = 0; j < 2; j++) begin
            wv[j] = 1'b0;
            w[j]  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                if (wild) wv[j] = 1'b1;
                else if (w[j] != 5'd0 && avail[w[j]] > 0) begin
                    avail[w[j]]--;
                    wv[j] = 1'b1;
                end
            end
        end
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              wv, w[0], w[1], 1'($urandom_range(0, 39) == 0));
        step(wild ? "rnd_wild" : "rnd");
    endtask

    initial begin
        model_clear();
        idle();
        reset_i = 1'b1;
        #2;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_ready", 32'(issue_ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // RAW on x5, then cleared by a same-cycle writeback
        drive(1, 1, 5'd5, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        step("raw_issue");
        drive(1, 0, 5'd0, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("raw_hz_set", 32'(hazard_o), 32'd1);
        check("raw_not_ready", 32'(issue_ready_o), 32'd0);
        step("raw_block");
        drive(1, 0, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 0);
        #1;
        check("raw_bypass_ready", 32'(issue_ready_o), 32'd1);
        step("raw_bypass");

        // WAW depth on x7
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'd7, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
            step("waw_fill");
        end
        drive(1, 1, 5'd7, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("waw_full_block", 32'(issue_ready_o), 32'd0);
        step("waw_block");
        drive(1, 1, 5'd7, 2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 0);
        #1;
        check("waw_retire_accept", 32'(issue_ready_o), 32'd1);
        step("waw_swap");
        drive(1, 1, 5'd7, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("waw_still_full", 32'(issue_ready_o), 32'd0);
        step("waw_still");
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 5'd7, 0);
        step("waw_drain2");
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 0);
        step("waw_drain1");

        // Dual retire of x9
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 5'd9, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
            step("dual_fill");
        end
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd9, 5'd9, 0);
        step("dual_retire");
        idle();
        #1;
        check("dual_busy", 32'(busy_o), 32'd0);
        check("dual_error", 32'(error_o), 32'd0);
        step("dual_idle");

        // x0 and unchecked sources
        drive(1, 1, 5'd0, 2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("x0_ready", 32'(issue_ready_o), 32'd1);
        check("x0_hazard", 32'(hazard_o), 32'd0);
        step("x0_issue");
        drive(1, 1, 5'd5, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("x0_no_count", 32'(busy_o), 32'd0);
        step("unchk_fill");
        drive(1, 0, 5'd0, 2'b01, 5'd1, 5'd5, 2'b00, 5'd0, 5'd0, 0);
        #1;
        check("unchk_ready", 32'(issue_ready_o), 32'd1);
        step("unchk");
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd5, 0);
        step("unchk_drain");

        // Flush, then a late retire sets the sticky error
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 5'd3, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
            step("flush_fill");
        end
        drive(1, 1, 5'd3, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1);
        #1;
        check("flush_not_ready", 32'(issue_ready_o), 32'd0);
        step("flush");
        idle();
        #1;
        check("flush_busy", 32'(busy_o), 32'd0);
        step("flush_idle");
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 0);
        step("late_retire");
        idle();
        #1;
        check("err_set", 32'(error_o), 32'd1);
        step("err_hold1");
        drive(0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1);
        step("err_flush");
        idle();
        #1;
        check("err_sticky", 32'(error_o), 32'd1);

        // Asynchronous reset mid-cycle with state pending
        drive(1, 1, 5'd4, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0);
        step("pre_reset");
        idle();
        #3 reset_i = 1'b1;
        #1;
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_error", 32'(error_o), 32'd0);
        check("async_ready", 32'(issue_ready_o), 32'd1);
        model_clear();
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        for (int n = 0; n < 400; n++) rand_cycle(1'b0);
        for (int n = 0; n < 200; n++) rand_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
